// File: rtl/rob_pkg.sv
// Shared reorder-buffer definitions: depth, entry-index type and the entry
// record. Imported by the ROB and by dispatch/execution units that carry
// ROB indices.
package rob_pkg;

   localparam int ROB_DEPTH = 16;
   localparam int ROB_IDX_W = $clog2(ROB_DEPTH);
   localparam int REG_W     = 5;
   localparam int DATA_W    = 32;

   typedef logic [ROB_IDX_W-1:0] rob_idx_t;

   typedef struct packed {
      logic              valid;
      logic              done;
      logic              exc;
      logic              wen;
      logic [REG_W-1:0]  dest;
      logic [DATA_W-1:0] data;
   } rob_entry_t;

endpackage

// File: rtl/rob_retire_if.sv
// Bundle between the core (dispatch, execution writeback, flush control,
// register file) and the reorder buffer.
//   master : core side - drives allocation, writeback and flush, receives
//            allocation indices and register-file write ports.
//   slave  : ROB side.
interface rob_retire_if #(
   parameter int IDX_W = rob_pkg::ROB_IDX_W
);
   logic             alloc0_valid;
   logic [4:0]       alloc0_dest;
   logic             alloc0_wen;
   logic             alloc1_valid;
   logic [4:0]       alloc1_dest;
   logic             alloc1_wen;
   logic             alloc_ready;
   logic [IDX_W-1:0] alloc0_idx;
   logic [IDX_W-1:0] alloc1_idx;

   logic             wb0_valid;
   logic [IDX_W-1:0] wb0_idx;
   logic [31:0]      wb0_data;
   logic             wb0_exc;
   logic             wb1_valid;
   logic [IDX_W-1:0] wb1_idx;
   logic [31:0]      wb1_data;
   logic             wb1_exc;

   logic             flush;

   logic [4:0]       waddr0;
   logic [4:0]       waddr1;
   logic             wen0;
   logic             wen1;
   logic [31:0]      wdata0;
   logic [31:0]      wdata1;
   logic             exc_commit;
   logic [IDX_W-1:0] exc_idx;

   modport master (
      output alloc0_valid, alloc0_dest, alloc0_wen,
      output alloc1_valid, alloc1_dest, alloc1_wen,
      input  alloc_ready, alloc0_idx, alloc1_idx,
      output wb0_valid, wb0_idx, wb0_data, wb0_exc,
      output wb1_valid, wb1_idx, wb1_data, wb1_exc,
      output flush,
      input  waddr0, waddr1, wen0, wen1, wdata0, wdata1,
      input  exc_commit, exc_idx
   );

   modport slave (
      input  alloc0_valid, alloc0_dest, alloc0_wen,
      input  alloc1_valid, alloc1_dest, alloc1_wen,
      output alloc_ready, alloc0_idx, alloc1_idx,
      input  wb0_valid, wb0_idx, wb0_data, wb0_exc,
      input  wb1_valid, wb1_idx, wb1_data, wb1_exc,
      input  flush,
      output waddr0, waddr1, wen0, wen1, wdata0, wdata1,
      output exc_commit, exc_idx
   );

endinterface

// File: rtl/rob_retire_sel.sv
// Retire selection for the two oldest ROB entries. Purely combinational.
//   flush         : suppresses all retirement
//   head_idx      : index of the oldest entry
//   head_e/next_e : entries at head and head+1
//   c0/c1         : slot 0 / slot 1 retires this cycle
//   wen*/waddr*/wdata* : register-file write ports (port 1 = younger)
//   exc_commit/exc_idx : head retired carrying an exception
module rob_retire_sel
   import rob_pkg::*;
#(
   parameter int IDX_W = ROB_IDX_W
) (
   input  logic             flush,
   input  logic [IDX_W-1:0] head_idx,
   input  rob_entry_t       head_e,
   input  rob_entry_t       next_e,
   output logic             c0,
   output logic             c1,
   output logic             wen0,
   output logic [4:0]       waddr0,
   output logic [31:0]      wdata0,
   output logic             wen1,
   output logic [4:0]       waddr1,
   output logic [31:0]      wdata1,
   output logic             exc_commit,
   output logic [IDX_W-1:0] exc_idx
);

   assign c0 = ~flush & head_e.valid & head_e.done;
   // An excepting head stops slot 1 from retiring behind it.
   assign c1 = c0 & ~head_e.exc & next_e.valid & next_e.done & ~next_e.exc;

   // r0 is hardwired; writes to it are dropped but the entry still retires.
   assign wen0   = c0 & ~head_e.exc & head_e.wen & (head_e.dest != 5'd0);
   assign waddr0 = head_e.dest;
   assign wdata0 = head_e.data;

   assign wen1   = c1 & next_e.wen & (next_e.dest != 5'd0);
   assign waddr1 = next_e.dest;
   assign wdata1 = next_e.data;

   assign exc_commit = c0 & head_e.exc;
   assign exc_idx    = head_idx;

endmodule

// File: rtl/rob_retire.sv
// 2-wide in-order-retire reorder buffer, writer side of the architectural
// register file.
//   clk, resetn : clock, synchronous active-low reset
//   rob         : slave side of rob_retire_if (allocation, writeback, flush,
//                 register-file write ports, exception commit)
module rob_retire
   import rob_pkg::*;
#(
   parameter int DEPTH = ROB_DEPTH,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic       clk,
   input  logic       resetn,
   rob_retire_if.slave rob
);

   localparam logic [IDX_W:0] READY_MAX = (IDX_W+1)'(DEPTH - 2);

   rob_entry_t       entry_q [DEPTH];
   rob_entry_t       entry_d [DEPTH];
   logic [IDX_W-1:0] head_q, head_d;
   logic [IDX_W-1:0] tail_q, tail_d;
   logic [IDX_W:0]   count_q, count_d;

   logic [IDX_W-1:0] head_p1, tail_p1;
   logic             alloc_ready;
   logic             acc0, acc1;
   logic [IDX_W:0]   n_acc, n_ret;

   logic             c0, c1;
   logic             wen0, wen1, exc_commit;
   logic [4:0]       waddr0, waddr1;
   logic [31:0]      wdata0, wdata1;
   logic [IDX_W-1:0] exc_idx;

   assign head_p1 = head_q + IDX_W'(1);
   assign tail_p1 = tail_q + IDX_W'(1);

   // Only the registered count is used, so a retire this cycle never
   // opens space for an allocation in the same cycle.
   assign alloc_ready = (count_q <= READY_MAX);
   assign acc0        = rob.alloc0_valid & alloc_ready & ~rob.flush;
   assign acc1        = acc0 & rob.alloc1_valid;
   assign n_acc       = (IDX_W+1)'(acc0) + (IDX_W+1)'(acc1);
   assign n_ret       = (IDX_W+1)'(c0) + (IDX_W+1)'(c1);

   rob_retire_sel #(.IDX_W(IDX_W)) u_sel (
      .flush      (rob.flush),
      .head_idx   (head_q),
      .head_e     (entry_q[head_q]),
      .next_e     (entry_q[head_p1]),
      .c0         (c0),
      .c1         (c1),
      .wen0       (wen0),
      .waddr0     (waddr0),
      .wdata0     (wdata0),
      .wen1       (wen1),
      .waddr1     (waddr1),
      .wdata1     (wdata1),
      .exc_commit (exc_commit),
      .exc_idx    (exc_idx)
   );

   always_comb begin
      entry_d = entry_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (rob.flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_d[i].valid = 1'b0;
            entry_d[i].done  = 1'b0;
            entry_d[i].exc   = 1'b0;
         end
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         // wb1 applied last so it wins on an index collision.
         if (rob.wb0_valid && entry_q[rob.wb0_idx].valid) begin
            entry_d[rob.wb0_idx].done = 1'b1;
            entry_d[rob.wb0_idx].data = rob.wb0_data;
            entry_d[rob.wb0_idx].exc  = rob.wb0_exc;
         end
         if (rob.wb1_valid && entry_q[rob.wb1_idx].valid) begin
            entry_d[rob.wb1_idx].done = 1'b1;
            entry_d[rob.wb1_idx].data = rob.wb1_data;
            entry_d[rob.wb1_idx].exc  = rob.wb1_exc;
         end
         if (c0) entry_d[head_q].valid  = 1'b0;
         if (c1) entry_d[head_p1].valid = 1'b0;
         // Allocation targets are free slots whenever alloc_ready is high,
         // so they never collide with the writeback/retire updates above.
         if (acc0) begin
            entry_d[tail_q].valid = 1'b1;
            entry_d[tail_q].done  = 1'b0;
            entry_d[tail_q].exc   = 1'b0;
            entry_d[tail_q].wen   = rob.alloc0_wen;
            entry_d[tail_q].dest  = rob.alloc0_dest;
         end
         if (acc1) begin
            entry_d[tail_p1].valid = 1'b1;
            entry_d[tail_p1].done  = 1'b0;
            entry_d[tail_p1].exc   = 1'b0;
            entry_d[tail_p1].wen   = rob.alloc1_wen;
            entry_d[tail_p1].dest  = rob.alloc1_dest;
         end
         head_d  = head_q + n_ret[IDX_W-1:0];
         tail_d  = tail_q + n_acc[IDX_W-1:0];
         count_d = count_q + n_acc - n_ret;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         entry_q <= entry_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign rob.alloc_ready = alloc_ready;
   assign rob.alloc0_idx  = tail_q;
   assign rob.alloc1_idx  = tail_p1;
   assign rob.wen0        = wen0;
   assign rob.waddr0      = waddr0;
   assign rob.wdata0      = wdata0;
   assign rob.wen1        = wen1;
   assign rob.waddr1      = waddr1;
   assign rob.wdata1      = wdata1;
   assign rob.exc_commit  = exc_commit;
   assign rob.exc_idx     = exc_idx;

endmodule

// File: tb/tb_rob_retire.sv
// Bench for rob_retire: directed scenarios followed by random traffic, all
// checked against an in-order queue model of the in-flight instructions.
module tb_rob_retire;
   import rob_pkg::*;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   rob_retire_if bus ();
   rob_retire dut (.clk(clk), .resetn(resetn), .rob(bus));

   typedef struct {
      logic [3:0]  idx;
      logic [4:0]  dest;
      logic        wen;
      logic        done;
      logic        exc;
      logic [31:0] data;
   } m_ent_t;

   m_ent_t      q[$];
   logic [3:0]  m_tail = 4'd0;
   logic [31:0] rf [32];
   int          n_checks = 0;
   int          n_fail = 0;

   logic e_c0, e_c1, e_ready, e_wen0, e_wen1, e_exc;
   logic o_wen0, o_wen1;
   logic [4:0]  o_waddr0, o_waddr1;
   logic [31:0] o_wdata0, o_wdata1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_calc();
      e_ready = (ROB_DEPTH - q.size()) >= 2;
      e_c0    = !bus.flush && q.size() > 0 && q[0].done;
      e_c1    = e_c0 && !q[0].exc && q.size() > 1 && q[1].done && !q[1].exc;
      e_wen0  = e_c0 && !q[0].exc && q[0].wen && q[0].dest != 5'd0;
      e_wen1  = e_c1 && q[1].wen && q[1].dest != 5'd0;
      e_exc   = e_c0 && q[0].exc;
   endtask

   task automatic idle();
      bus.alloc0_valid = 0; bus.alloc0_dest = 0; bus.alloc0_wen = 0;
      bus.alloc1_valid = 0; bus.alloc1_dest = 0; bus.alloc1_wen = 0;
      bus.wb0_valid = 0; bus.wb0_idx = 0; bus.wb0_data = 0; bus.wb0_exc = 0;
      bus.wb1_valid = 0; bus.wb1_idx = 0; bus.wb1_data = 0; bus.wb1_exc = 0;
      bus.flush = 0;
   endtask

   task automatic sample();
      logic [3:0] t1;
      @(negedge clk);
      o_wen0 = bus.wen0; o_waddr0 = bus.waddr0; o_wdata0 = bus.wdata0;
      o_wen1 = bus.wen1; o_waddr1 = bus.waddr1; o_wdata1 = bus.wdata1;
      if (resetn) begin
         expect_calc();
         t1 = m_tail + 4'd1;
         check("alloc_ready", 32'(bus.alloc_ready), 32'(e_ready));
         check("alloc0_idx", 32'(bus.alloc0_idx), 32'(m_tail));
         check("alloc1_idx", 32'(bus.alloc1_idx), 32'(t1));
         check("wen0", 32'(bus.wen0), 32'(e_wen0));
         check("wen1", 32'(bus.wen1), 32'(e_wen1));
         check("exc_commit", 32'(bus.exc_commit), 32'(e_exc));
         check("count", 32'(dut.count_q), q.size());
         if (e_wen0) begin
            check("waddr0", 32'(bus.waddr0), 32'(q[0].dest));
            check("wdata0", bus.wdata0, q[0].data);
         end
         if (e_wen1) begin
            check("waddr1", 32'(bus.waddr1), 32'(q[1].dest));
            check("wdata1", bus.wdata1, q[1].data);
         end
         if (e_exc) check("exc_idx", 32'(bus.exc_idx), 32'(q[0].idx));
      end
   endtask

   task automatic tick();
      m_ent_t e;
      @(posedge clk);
      if (!resetn || bus.flush) begin
         q.delete();
         m_tail = 4'd0;
      end else begin
         expect_calc();
         if (o_wen0) rf[o_waddr0] = o_wdata0;
         if (o_wen1) rf[o_waddr1] = o_wdata1;
         if (e_c0) void'(q.pop_front());
         if (e_c1) void'(q.pop_front());
         for (int k = 0; k < q.size(); k++)
            if (bus.wb0_valid && q[k].idx == bus.wb0_idx) begin
               q[k].done = 1'b1; q[k].data = bus.wb0_data; q[k].exc = bus.wb0_exc;
            end
         for (int k = 0; k < q.size(); k++)
            if (bus.wb1_valid && q[k].idx == bus.wb1_idx) begin
               q[k].done = 1'b1; q[k].data = bus.wb1_data; q[k].exc = bus.wb1_exc;
            end
         if (e_ready && bus.alloc0_valid) begin
            e = '{idx: m_tail, dest: bus.alloc0_dest, wen: bus.alloc0_wen,
                  done: 1'b0, exc: 1'b0, data: 32'd0};
            q.push_back(e);
            m_tail = m_tail + 4'd1;
            if (bus.alloc1_valid) begin
               e = '{idx: m_tail, dest: bus.alloc1_dest, wen: bus.alloc1_wen,
                     done: 1'b0, exc: 1'b0, data: 32'd0};
               q.push_back(e);
               m_tail = m_tail + 4'd1;
            end
         end
      end
      #1;
   endtask

   task automatic go();
      sample();
      tick();
   endtask

   task automatic alloc_pair(input logic [4:0] d0, input logic w0,
                             input logic [4:0] d1, input logic w1);
      idle();
      bus.alloc0_valid = 1; bus.alloc0_dest = d0; bus.alloc0_wen = w0;
      bus.alloc1_valid = 1; bus.alloc1_dest = d1; bus.alloc1_wen = w1;
      go();
      idle();
   endtask

   task automatic do_flush();
      idle();
      bus.flush = 1;
      go();
      idle();
   endtask

   initial begin
      int k;
      for (int i = 0; i < 32; i++) rf[i] = 32'd0;
      idle();

      // Reset
      resetn = 0;
      go(); go();
      resetn = 1;
      sample();
      check("rst_ready", 32'(bus.alloc_ready), 32'd1);
      check("rst_wen0", 32'(bus.wen0), 32'd0);
      check("rst_wen1", 32'(bus.wen1), 32'd0);
      check("rst_exc", 32'(bus.exc_commit), 32'd0);
      tick();

      // Out-of-order writeback, in-order dual retire
      alloc_pair(5'd3, 1'b1, 5'd5, 1'b1);
      bus.wb0_valid = 1; bus.wb0_idx = 4'd1; bus.wb0_data = 32'hB; go(); idle();
      bus.wb1_valid = 1; bus.wb1_idx = 4'd0; bus.wb1_data = 32'hA; go(); idle();
      sample();
      check("dual_wen0", 32'(bus.wen0), 32'd1);
      check("dual_waddr0", 32'(bus.waddr0), 32'd3);
      check("dual_wdata0", bus.wdata0, 32'hA);
      check("dual_wen1", 32'(bus.wen1), 32'd1);
      check("dual_waddr1", 32'(bus.waddr1), 32'd5);
      check("dual_wdata1", bus.wdata1, 32'hB);
      tick();
      sample();
      check("dual_count0", 32'(dut.count_q), 32'd0);
      tick();

      // Fill to 15, single allocation refused, then fill to 16 across the wrap
      for (int i = 0; i < 15; i++) begin
         idle();
         bus.alloc0_valid = 1; bus.alloc0_dest = 5'(i + 1); bus.alloc0_wen = 1;
         go();
      end
      sample();
      check("cnt15_ready", 32'(bus.alloc_ready), 32'd0);
      tick();
      bus.wb0_valid = 1; bus.wb0_idx = q[0].idx; bus.wb0_data = 32'h100;
      go();
      bus.wb0_valid = 0;
      go();
      alloc_pair(5'd20, 1'b1, 5'd21, 1'b1);
      sample();
      check("full_ready", 32'(bus.alloc_ready), 32'd0);
      check("full_count", 32'(dut.count_q), 32'd16);
      tick();
      bus.alloc0_valid = 1; bus.alloc0_dest = 5'd22; bus.alloc0_wen = 1;
      bus.wb0_valid = 1; bus.wb0_idx = q[0].idx; bus.wb0_data = 32'h200;
      go();
      bus.wb0_valid = 0;
      go();
      do_flush();

      // Same destination in both slots: younger value lands
      alloc_pair(5'd7, 1'b1, 5'd7, 1'b1);
      bus.wb0_valid = 1; bus.wb0_idx = 4'd0; bus.wb0_data = 32'h11;
      bus.wb1_valid = 1; bus.wb1_idx = 4'd1; bus.wb1_data = 32'h22;
      go(); idle();
      sample();
      check("same_wen0", 32'(bus.wen0), 32'd1);
      check("same_wen1", 32'(bus.wen1), 32'd1);
      check("same_waddr0", 32'(bus.waddr0), 32'd7);
      check("same_waddr1", 32'(bus.waddr1), 32'd7);
      tick();
      check("rf_r7", rf[7], 32'h22);

      // Exception at head
      alloc_pair(5'd9, 1'b1, 5'd10, 1'b1);
      bus.wb0_valid = 1; bus.wb0_idx = 4'd2; bus.wb0_data = 32'h33; bus.wb0_exc = 1;
      bus.wb1_valid = 1; bus.wb1_idx = 4'd3; bus.wb1_data = 32'h44;
      go(); idle();
      sample();
      check("exc_commit", 32'(bus.exc_commit), 32'd1);
      check("exc_idx_hd", 32'(bus.exc_idx), 32'd2);
      check("exc_wen0", 32'(bus.wen0), 32'd0);
      check("exc_wen1", 32'(bus.wen1), 32'd0);
      tick();
      sample();
      check("exc_one_left", 32'(dut.count_q), 32'd1);
      tick();
      do_flush();
      sample();
      check("flush_ready", 32'(bus.alloc_ready), 32'd1);
      check("flush_count", 32'(dut.count_q), 32'd0);
      tick();

      // r0 destination and wen=0 retire without writing
      alloc_pair(5'd0, 1'b1, 5'd4, 1'b0);
      bus.wb0_valid = 1; bus.wb0_idx = 4'd0; bus.wb0_data = 32'h55;
      bus.wb1_valid = 1; bus.wb1_idx = 4'd1; bus.wb1_data = 32'h66;
      go(); idle();
      sample();
      check("r0_wen0", 32'(bus.wen0), 32'd0);
      check("nowen_wen1", 32'(bus.wen1), 32'd0);
      tick();
      sample();
      check("r0_removed", 32'(dut.count_q), 32'd0);
      tick();

      // Flush with completed entries in flight, then a stale writeback
      alloc_pair(5'd1, 1'b1, 5'd2, 1'b1);
      alloc_pair(5'd3, 1'b1, 5'd4, 1'b1);
      alloc_pair(5'd5, 1'b1, 5'd6, 1'b1);
      bus.wb0_valid = 1; bus.wb0_idx = q[0].idx; bus.wb0_data = 32'h77;
      bus.wb1_valid = 1; bus.wb1_idx = q[1].idx; bus.wb1_data = 32'h88;
      go(); idle();
      bus.flush = 1;
      sample();
      check("fl_wen0", 32'(bus.wen0), 32'd0);
      check("fl_wen1", 32'(bus.wen1), 32'd0);
      tick();
      idle();
      sample();
      check("fl_tail0", 32'(bus.alloc0_idx), 32'd0);
      tick();
      bus.wb0_valid = 1; bus.wb0_idx = 4'd2; bus.wb0_data = 32'h99; go(); idle();
      alloc_pair(5'd11, 1'b1, 5'd12, 1'b1);
      bus.alloc0_valid = 1; bus.alloc0_dest = 5'd13; bus.alloc0_wen = 1; go(); idle();
      bus.wb0_valid = 1; bus.wb0_idx = 4'd0; bus.wb0_data = 32'hA0;
      bus.wb1_valid = 1; bus.wb1_idx = 4'd1; bus.wb1_data = 32'hA1;
      go(); idle();
      go();
      sample();
      check("stale_wen0", 32'(bus.wen0), 32'd0);
      check("stale_pending", 32'(dut.count_q), 32'd1);
      tick();
      do_flush();

      // Random traffic
      for (int cyc = 0; cyc < 3000; cyc++) begin
         idle();
         resetn = ($urandom_range(0, 199) != 0);
         bus.flush = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 9) < 6) begin
            bus.alloc0_valid = 1;
            bus.alloc0_dest = 5'($urandom);
            bus.alloc0_wen = 1'($urandom);
            if ($urandom_range(0, 1) == 1) begin
               bus.alloc1_valid = 1;
               bus.alloc1_dest = 5'($urandom);
               bus.alloc1_wen = 1'($urandom);
            end
         end
         bus.wb0_valid = ($urandom_range(0, 9) < 7);
         if (q.size() > 0 && $urandom_range(0, 9) < 8) begin
            k = $urandom_range(0, q.size() - 1);
            bus.wb0_idx = q[k].idx;
         end else bus.wb0_idx = 4'($urandom);
         bus.wb0_data = $urandom;
         bus.wb0_exc = ($urandom_range(0, 19) == 0);
         bus.wb1_valid = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 9) == 0) bus.wb1_idx = bus.wb0_idx;
         else if (q.size() > 0 && $urandom_range(0, 9) < 8) begin
            k = $urandom_range(0, q.size() - 1);
            bus.wb1_idx = q[k].idx;
         end else bus.wb1_idx = 4'($urandom);
         bus.wb1_data = $urandom;
         bus.wb1_exc = ($urandom_range(0, 19) == 0);
         go();
      end
      idle();
      resetn = 1;
      go();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
